// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the seven-segment scan driver:
//   SEG_OFF           - all segments dark (active-low pattern)
//   SEG_A .. SEG_G    - bit positions of each segment in a 7-bit pattern
//   HEX_SEG           - active-low pattern for each hex nibble 0..F
//   hex_to_seg()      - table lookup helper
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Index = nibble value. Lower-case b and d keep them distinct from 8 and 0.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
// Combinational hex nibble to active-low seven-segment pattern.
// Ports:
//   nibble  in  4  hex digit 0..F
//   seg     out 7  active-low segments, bit 0 = a ... bit 6 = g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed hex display driver. A DIGITS-wide hex value is held in a
// pending/active register pair; the active copy is scanned one digit per
// TICK_DIV-cycle slot onto a shared active-low segment bus.
//
// Ports:
//   clk        in   1         system clock
//   rst        in   1         asynchronous active-high reset
//   load       in   1         single-cycle strobe capturing value/dp_in/en_mask
//   value      in   4*DIGITS  hex nibbles, nibble i drives digit i
//   dp_in      in   DIGITS    decimal point per digit, 1 = lit
//   en_mask    in   DIGITS    per-digit enable, 0 = digit dark
//   seg_n      out  7         active-low segments, bit 0 = a ... bit 6 = g
//   dp_n       out  1         active-low decimal point
//   an_n       out  DIGITS    active-low digit select, at most one low
//   frame_done out  1         pulse in the cycle after the last slot ends
//
// Handshake: load has no ready; every cycle with load high is accepted. The
// captured data waits in the pending register and is promoted to the active
// register only at the frame boundary, so a frame never mixes two values.
//
// Build option: define SEG7_BLANK_LZ_EN to blank leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_mask,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic                tick;
    logic                wrap;

    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_en;
    logic                pend_flag;

    logic [4*DIGITS-1:0] act_value;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_en;
    logic [4*DIGITS-1:0] act_value_nxt;
    logic [DIGITS-1:0]   act_dp_nxt;
    logic [DIGITS-1:0]   act_en_nxt;

    logic [3:0]          cur_nibble;
    logic                cur_en;
    logic                cur_dp;
    logic                blank;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   an_sel;

    assign tick    = (div == DIV_LAST);
    assign wrap    = tick && (idx == IDX_LAST);
    assign idx_nxt = wrap ? '0 : idx + 1'b1;

    // Slot timing: divider and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (tick) begin
            div <= '0;
            idx <= idx_nxt;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Next active contents. A load landing on the wrap tick bypasses the
    // pending register so it is shown in the frame that starts next cycle.
    always_comb begin
        act_value_nxt = act_value;
        act_dp_nxt    = act_dp;
        act_en_nxt    = act_en;
        if (wrap) begin
            if (load) begin
                act_value_nxt = value;
                act_dp_nxt    = dp_in;
                act_en_nxt    = en_mask;
            end else if (pend_flag) begin
                act_value_nxt = pend_value;
                act_dp_nxt    = pend_dp;
                act_en_nxt    = pend_en;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_flag  <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_en     <= '0;
        end else begin
            act_value <= act_value_nxt;
            act_dp    <= act_dp_nxt;
            act_en    <= act_en_nxt;
            if (load && !wrap) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_en    <= en_mask;
                pend_flag  <= 1'b1;
            end else if (wrap) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // Output registers load on tick, so the muxing looks at the digit and
    // active data that will be current after this edge.
    assign cur_nibble = act_value_nxt[{idx_nxt, 2'b00} +: 4];
    assign cur_en     = act_en_nxt[idx_nxt];
    assign cur_dp     = act_dp_nxt[idx_nxt];
    assign an_sel     = DIGITS'(1) << idx_nxt;

`ifdef SEG7_BLANK_LZ_EN
    // lz[i]: nibble i and every nibble above it are zero.
    logic [DIGITS-1:0] lz;
    always_comb begin
        lz = '0;
        lz[DIGITS-1] = (act_value_nxt[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] && (act_value_nxt[4*i +: 4] == 4'h0);
        end
    end
    // Digit 0 always shows, so a value of zero still displays "0".
    assign blank = (idx_nxt != '0) && lz[idx_nxt];
`else
    assign blank = 1'b0;
`endif

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                if (cur_en && !blank) begin
                    seg_n <= dec_seg;
                    dp_n  <= ~cur_dp;
                    an_n  <= ~an_sel;
                end else begin
                    // Dark slot: still takes its full time in the frame.
                    seg_n <= SEG_OFF;
                    dp_n  <= 1'b1;
                    an_n  <= '1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Drives seg7_scan_driver (DIGITS=4, TICK_DIV=4) with directed and random
// loads. A frame-level model (edge count since reset, last load before each
// frame boundary) predicts every output each cycle; a few literal frames pin
// the model. Honours SEG7_BLANK_LZ_EN the same way as the design.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int T     = 4;
  localparam int FRAME = D * T;

  logic           clk;
  logic           rst;
  logic           load;
  logic [4*D-1:0] value;
  logic [D-1:0]   dp_in;
  logic [D-1:0]   en_mask;
  logic [6:0]     seg_n;
  logic           dp_n;
  logic [D-1:0]   an_n;
  logic           frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc_fail_prints = 0;

  seg7_scan_driver #(.DIGITS(D), .TICK_DIV(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .en_mask    (en_mask),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [4*D-1:0] v;
    logic [D-1:0]   d;
    logic [D-1:0]   e;
  } ld_t;

  ld_t            load_q[$];   // loads seen since the last frame boundary
  int             m_c   = 0;   // rising edges since reset release
  logic [4*D-1:0] m_val = '0;
  logic [D-1:0]   m_dp  = '0;
  logic [D-1:0]   m_en  = '0;

  initial begin
    ld_t ld;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_c = 0; m_val = '0; m_dp = '0; m_en = '0;
        load_q.delete();
      end else begin
        m_c++;
        if (load) load_q.push_back('{value, dp_in, en_mask});
        if ((m_c % FRAME) == 0 && load_q.size() > 0) begin
          ld = load_q[$];
          m_val = ld.v; m_dp = ld.d; m_en = ld.e;
          load_q.delete();
        end
      end
    end
  end

  // Outputs after edge m_c: nothing shown before the first slot ends;
  // afterwards digit (m_c / T) mod D of the frame's data.
  task automatic model_expect(output logic [6:0] es, output logic ed,
                              output logic [D-1:0] ea, output logic ef);
    int k;
    logic [3:0] nib;
    logic show;
    ef = (m_c > 0) && ((m_c % FRAME) == 0);
    es = 7'h7F; ed = 1'b1; ea = '1;
    if (m_c >= T) begin
      k    = (m_c / T) % D;
      nib  = 4'((m_val >> (4 * k)) & 16'hF);
      show = m_en[k];
`ifdef SEG7_BLANK_LZ_EN
      if (k >= 1 && (m_val >> (4 * k)) == 0) show = 1'b0;
`endif
      if (show) begin
        es = hex_tab[nib];
        ed = ~m_dp[k];
        ea = ~(D'(1) << k);
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [6:0] es; logic ed; logic [D-1:0] ea; logic ef;
    forever begin
      @(negedge clk);
      model_expect(es, ed, ea, ef);
      n_cmp++;
      if ({seg_n, dp_n, an_n, frame_done} !== {es, ed, ea, ef}) begin
        n_bad++;
        if (n_cyc_fail_prints < 20) begin
          n_cyc_fail_prints++;
          $display("FAIL cycle t=%0t c=%0d: got seg_n=%h dp_n=%b an_n=%h fd=%b, want seg_n=%h dp_n=%b an_n=%h fd=%b",
                   $time, m_c, seg_n, dp_n, an_n, frame_done, es, ed, ea, ef);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive_load(input logic [4*D-1:0] v, input logic [D-1:0] d, input logic [D-1:0] e);
    @(posedge clk); #2;
    load = 1'b1; value = v; dp_in = d; en_mask = e;
    @(posedge clk); #2;
    load = 1'b0;
    value = 16'($urandom); dp_in = 4'($urandom); en_mask = 4'($urandom);
  endtask

  // Leaves the bench just after the edge with m_c % FRAME == p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((m_c % FRAME) != p && n < 4 * FRAME);
    check("wait_phase", 32'((m_c % FRAME) == p), 32'd1);
  endtask

  // Stops on the negedge where frame_done is high.
  task automatic wait_frame(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check({name, "_frame_seen"}, 32'(frame_done), 32'd1);
  endtask

  // segs/ans/dps packed with digit 3 in the top field.
  task automatic pin_frame(input string name, input logic [27:0] segs,
                           input logic [15:0] ans, input logic [3:0] dps);
    logic [6:0] es; logic ed; logic [D-1:0] ea; logic ef;
    for (int j = 0; j < D; j++) begin
      model_expect(es, ed, ea, ef);
      check($sformatf("%s_d%0d_seg", name, j), 32'(seg_n), 32'(segs[7*j +: 7]));
      check($sformatf("%s_d%0d_an", name, j), 32'(an_n), 32'(ans[4*j +: 4]));
      check($sformatf("%s_d%0d_dp", name, j), 32'(dp_n), 32'(dps[j]));
      check($sformatf("%s_d%0d_model", name, j), {21'd0, es, ea}, {21'd0, segs[7*j +: 7], ans[4*j +: 4]});
      if (j < D - 1) repeat (T) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_seg"}, 32'(seg_n), 32'h7F);
    check({name, "_dp"}, 32'(dp_n), 32'd1);
    check({name, "_an"}, 32'(an_n), 32'hF);
    check({name, "_fd"}, 32'(frame_done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd_cnt;
    rst = 1'b0; load = 1'b0; value = '0; dp_in = '0; en_mask = '0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Idle: dark every cycle, frame_done every FRAME cycles (c = 16, 32, 48).
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
    end
    check("idle_frames", 32'(fd_cnt), 32'd3);

    // Basic frame.
    drive_load(16'h12AF, 4'h0, 4'hF);
    wait_frame("basic");
    pin_frame("basic", {7'h79, 7'h24, 7'h08, 7'h0E}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'hF);

    // Two loads in one frame: only the second is ever shown.
    wait_phase(1);
    drive_load(16'h1111, 4'h0, 4'hF);
    drive_load(16'h2222, 4'h0, 4'hF);
    wait_frame("dbl");
    pin_frame("dbl", {7'h24, 7'h24, 7'h24, 7'h24}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'hF);

    // Load sampled on the wrap edge itself.
    wait_phase(FRAME - 2);
    drive_load(16'h0005, 4'h0, 4'hF);
    @(negedge clk);
    check("wrap_fd", 32'(frame_done), 32'd1);
    pin_frame("wrap", {7'h40, 7'h40, 7'h40, 7'h12}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'hF);

    // Leading zeros with a decimal point on digit 3.
    drive_load(16'h0050, 4'h8, 4'hF);
    wait_frame("lz");
`ifdef SEG7_BLANK_LZ_EN
    pin_frame("lz", {7'h7F, 7'h7F, 7'h12, 7'h40}, {4'hF, 4'hF, 4'hD, 4'hE}, 4'hF);
`else
    pin_frame("lz", {7'h40, 7'h40, 7'h12, 7'h40}, {4'h7, 4'hB, 4'hD, 4'hE}, 4'h7);
`endif

    // Reset in the middle of digit 2's slot, then reload with en_mask 0101.
    drive_load(16'h3210, 4'h0, 4'h5);
    wait_frame("pre_rst");
    repeat (2 * T + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(posedge clk); #2 rst = 1'b0;
    drive_load(16'h3210, 4'h0, 4'h5);
    wait_frame("post_rst");
    pin_frame("post_rst", {7'h7F, 7'h24, 7'h7F, 7'h40}, {4'hF, 4'hB, 4'hF, 4'hE}, 4'hF);

    // Random loads, occasional reset pulses; per-cycle compare checks all.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk); #1 rst = 1'b1;
        #1 check_reset_outputs("rand_rst");
        @(posedge clk); #2 rst = 1'b0;
      end
      drive_load(16'($urandom), 4'($urandom), 4'($urandom));
    end
    repeat (2 * FRAME + 2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
